// File: rtl/axi4_lite_master_arbiter.sv
// rtl/axi4_lite_master_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master
// Grants one requester at a time, pulses STARTW/STARTR, and returns the response on req_done.
module axi4_lite_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                    req_resp,
  output logic                          busy,
  output logic                          STARTW,
  output logic                          STARTR,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_bresp,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_write_done,
  input  logic                          m_read_done,
  input  logic                          m_idle
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       cur;
  logic [PTR_W-1:0]       win;
  logic [PTR_W:0]         idx;
  logic                   found;
  logic                   op;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First pending request scanning from ptr upward with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      op        <= 1'b0;
      req_gnt   <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      req_resp  <= '0;
      busy      <= 1'b0;
      STARTW    <= 1'b0;
      STARTR    <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_idle && found) begin
            cur     <= win;
            op      <= req_we[win];
            m_addr  <= addr_arr[win];
            m_wdata <= wdata_arr[win];
            req_gnt <= ONE << win;
            STARTW  <= req_we[win];
            STARTR  <= !req_we[win];
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          STARTW <= 1'b0;
          STARTR <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // Only the done pulse matching the launched direction completes.
          if (op ? m_write_done : m_read_done) begin
            req_resp <= op ? m_bresp : m_rresp;
            if (!op) req_rdata <= m_rdata;
            req_done <= req_gnt;
            req_gnt  <= '0;
            ptr      <= (cur == PTR_W'(NUM_REQ-1)) ? '0 : cur + PTR_W'(1);
            state    <= DONE;
          end
        end
        DONE: begin
          req_done <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// tb/tb_axi4_lite_master_arbiter.sv - self-checking bench for axi4_lite_master_arbiter
// Table-driven transactions with a completion scoreboard plus corner-case sequences.
module tb_axi4_lite_master_arbiter;
  localparam int N = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]  req_gnt;
  logic [N-1:0]  req_done;
  logic [31:0]   req_rdata;
  logic [1:0]    req_resp;
  logic          busy;
  logic          STARTW;
  logic          STARTR;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_bresp = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_write_done = 1'b0;
  logic          m_read_done = 1'b0;
  logic          m_idle = 1'b1;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .busy(busy), .STARTW(STARTW), .STARTR(STARTR), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_bresp(m_bresp), .m_rresp(m_rresp),
    .m_write_done(m_write_done), .m_read_done(m_read_done), .m_idle(m_idle)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          w;
  } vec_t;

  typedef struct {
    int          w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  vec_t        tbl [12];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input logic [1:0] rs,
                              input int lat, input int w);
    vec_t v;
    v.req = r; v.we = we; v.addr = a; v.wdata = d; v.rdata = rd; v.resp = rs; v.lat = lat; v.w = w;
    return v;
  endfunction

  // Only the expected winner sees the table address/data exactly; others are perturbed.
  task automatic drive_vec(input vec_t v);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = v.addr ^ (32'(i ^ v.w) << 24);
      req_wdata[i*32 +: 32] = v.wdata ^ (32'(i ^ v.w) << 8);
    end
    req    = v.req;
    req_we = v.we;
    e.w    = v.w;
    e.resp = v.resp;
    if (!v.we[v.w]) last_rd = v.rdata;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic wait_issue();
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (STARTW || STARTR) break;
    end
    check("issue_seen", 64'(STARTW | STARTR), 64'd1);
  endtask

  task automatic check_issue(input vec_t v);
    check("gnt", 64'(req_gnt), 64'(oh(v.w)));
    check("startw", 64'(STARTW), 64'(v.we[v.w]));
    check("startr", 64'(STARTR), 64'(!v.we[v.w]));
    check("m_addr", 64'(m_addr), 64'(v.addr));
    if (v.we[v.w]) check("m_wdata", 64'(m_wdata), 64'(v.wdata));
    check("busy_issue", 64'(busy), 64'd1);
  endtask

  task automatic serve(input vec_t v, input bit spur);
    exp_t e;
    @(negedge ACLK);
    check("strobe_1cyc", 64'({STARTW, STARTR}), 64'd0);
    check("gnt_hold", 64'(req_gnt), 64'(oh(v.w)));
    if (spur) begin
      m_rresp = 2'b11; m_rdata = 32'hFFFF_FFFF; m_read_done = 1'b1;
      @(negedge ACLK);
      m_read_done = 1'b0;
      check("spur_no_done", 64'(req_done), 64'd0);
      check("spur_busy", 64'(busy), 64'd1);
      check("spur_gnt", 64'(req_gnt), 64'(oh(v.w)));
    end
    repeat (v.lat) @(negedge ACLK);
    m_bresp = v.resp; m_rresp = v.resp; m_rdata = v.rdata;
    if (v.we[v.w]) m_write_done = 1'b1; else m_read_done = 1'b1;
    @(negedge ACLK);
    m_write_done = 1'b0; m_read_done = 1'b0; m_rdata = 32'h5A5A_5A5A;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty: got req_done %h expected no completion", req_done);
    end else begin
      e = sb.pop_front();
      check("req_done", 64'(req_done), 64'(oh(e.w)));
      check("req_resp", 64'(req_resp), 64'(e.resp));
      check("req_rdata", 64'(req_rdata), 64'(e.rdata));
      check("gnt_clear", 64'(req_gnt), 64'd0);
    end
    @(negedge ACLK);
    check("done_1cyc", 64'(req_done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    drive_vec(v);
    wait_issue();
    check_issue(v);
    serve(v, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 64'({req_gnt, req_done, req_resp, busy, STARTW, STARTR}), 64'd0);
    check({name, "_rdata"}, 64'(req_rdata), 64'd0);
    check({name, "_addr"}, 64'(m_addr), 64'd0);
    check({name, "_wdata"}, 64'(m_wdata), 64'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(4'b0001, 4'b0001, 32'h1000_0004, 32'hDEAD_BEEF, 32'hEEEE_0001, 2'b00, 2, 0);
    tbl[1]  = mk(4'b0100, 4'b0000, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 2'b00, 1, 2);
    tbl[2]  = mk(4'b1111, 4'b1010, 32'hA000_0300, 32'h1111_2222, 32'hEEEE_0002, 2'b10, 3, 3);
    tbl[3]  = mk(4'b0110, 4'b0000, 32'h0000_0404, 32'h0000_0000, 32'hCAFE_0001, 2'b11, 0, 1);
    tbl[4]  = mk(4'b0011, 4'b0011, 32'h0000_0500, 32'h3333_4444, 32'hEEEE_0003, 2'b01, 1, 0);
    tbl[5]  = mk(4'b1000, 4'b0000, 32'h0000_0600, 32'h0000_0000, 32'h0BAD_F00D, 2'b00, 0, 3);
    tbl[6]  = mk(4'b1111, 4'b0101, 32'h0000_0700, 32'hA0A0_0000, 32'hEEEE_0004, 2'b00, 1, 0);
    tbl[7]  = mk(4'b1111, 4'b0101, 32'h0000_0710, 32'hA0A0_0001, 32'h7100_0001, 2'b10, 0, 1);
    tbl[8]  = mk(4'b1111, 4'b0101, 32'h0000_0720, 32'hA0A0_0002, 32'hEEEE_0005, 2'b01, 2, 2);
    tbl[9]  = mk(4'b1111, 4'b0101, 32'h0000_0730, 32'hA0A0_0003, 32'h7300_0003, 2'b00, 1, 3);
    tbl[10] = mk(4'b1111, 4'b0101, 32'h0000_0740, 32'hA0A0_0004, 32'hEEEE_0006, 2'b00, 0, 0);
    tbl[11] = mk(4'b1111, 4'b0101, 32'h0000_0750, 32'hA0A0_0005, 32'h7500_0005, 2'b11, 1, 1);

    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESETN = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // m_idle low blocks arbitration; grant follows one cycle after it rises.
    v = mk(4'b0010, 4'b0000, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 2'b00, 1, 1);
    m_idle = 1'b0;
    drive_vec(v);
    repeat (4) begin
      @(negedge ACLK);
      check("idle_low_hold", 64'({req_gnt, busy, STARTW, STARTR}), 64'd0);
    end
    m_idle = 1'b1;
    @(negedge ACLK);
    check_issue(v);
    serve(v, 1'b0);

    // Spurious read-done during a write is ignored.
    v = mk(4'b0001, 4'b0001, 32'h0000_0900, 32'h5555_AAAA, 32'hEEEE_0009, 2'b00, 1, 0);
    drive_vec(v);
    wait_issue();
    check_issue(v);
    serve(v, 1'b1);

    // Reset while waiting aborts silently and resets the pointer.
    v = mk(4'b0100, 4'b0000, 32'h0000_0A00, 32'h0, 32'h7777_8888, 2'b00, 1, 2);
    drive_vec(v);
    wait_issue();
    check_issue(v);
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check_all_zero("mid_reset");
    ARESETN = 1'b1;
    sb.delete();
    last_rd = '0;
    v = mk(4'b1111, 4'b1111, 32'h0000_0B00, 32'h0000_9999, 32'hEEEE_000B, 2'b01, 0, 0);
    run_vec(v);

    req = '0;
    repeat (2) @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
